// File: rtl/alu_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : alu_wb_buffer
// Purpose  : In-order result queue between the ALU and register writeback.
//            Results targeting register x0 complete their handshake but are
//            dropped. A sticky flag records any accepted overflowing result.
// Ports    : CLK, RST            - clock, async active-high reset
//            flush               - synchronous discard of all queued entries
//            in_valid/in_ready   - ALU-side handshake
//            in_result/in_rd/in_overflow - ALU result, tag, overflow flag
//            out_valid/out_ready - writeback-side handshake
//            out_result/out_rd/out_overflow - head entry (zero when empty)
//            count               - number of queued entries
//            ovf_sticky/ovf_clear - sticky overflow flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module alu_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic [TAG_W-1:0]           in_rd,
  input  logic                       in_overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [TAG_W-1:0]           out_rd,
  output logic                       out_overflow,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf_sticky,
  input  logic                       ovf_clear
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 32 + TAG_W + 1;
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf_sticky;

  logic             w_push;
  logic             w_store;
  logic             w_pop;
  logic [ENT_W-1:0] w_head;

  // in_ready depends only on registered occupancy, never on out_ready,
  // so a full buffer does not accept even when a pop happens this cycle.
  assign in_ready  = (r_count < c_DEPTH);
  assign out_valid = (r_count != '0);

  assign w_push  = in_valid && in_ready;
  // x0 results are consumed but never occupy a slot
  assign w_store = w_push && (in_rd != '0);
  assign w_pop   = out_valid && out_ready;

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    out_result   = '0;
    out_rd       = '0;
    out_overflow = 1'b0;
    if (out_valid) begin
      out_result   = w_head[ENT_W-1 -: 32];
      out_rd       = w_head[TAG_W:1];
      out_overflow = w_head[0];
    end
  end

  assign count      = r_count;
  assign ovf_sticky = r_ovf_sticky;

  // Storage is not reset; the pointers and count alone define validity.
  always_ff @(posedge CLK) begin
    if (w_store && !flush) begin
      r_mem[r_wr_ptr] <= {in_result, in_rd, in_overflow};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Set has priority over clear; flush leaves the flag alone and an
  // overflowing push during a flush cycle still counts as accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_push && in_overflow) begin
      r_ovf_sticky <= 1'b1;
    end else if (ovf_clear) begin
      r_ovf_sticky <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_wb_buffer.md
ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result-queue entries; power of two, >= 2.
REQ-002 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous discard of all queued results.
REQ-006 SHALL have port in_valid  input  1  ALU result presented.
REQ-007 SHALL have port in_ready  output  1  buffer can accept a result this cycle.
REQ-008 SHALL have port in_result  input  32  ALU port_output value.
REQ-009 SHALL have port in_rd  input  TAG_W  destination register tag.
REQ-010 SHALL have port in_overflow  input  1  ALU signed-overflow flag for this result.
REQ-011 SHALL have port out_valid  output  1  head entry available to writeback.
REQ-012 SHALL have port out_ready  input  1  writeback accepts head entry.
REQ-013 SHALL have port out_result  output  32  head entry result.
REQ-014 SHALL have port out_rd  output  TAG_W  head entry tag.
REQ-015 SHALL have port out_overflow  output  1  head entry overflow flag.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  number of queued entries.
REQ-017 SHALL have port ovf_sticky  output  1  set once any accepted result overflowed.
REQ-018 SHALL have port ovf_clear  input  1  clears ovf_sticky.

Function
REQ-019 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend combinationally on out_ready or in_valid.
REQ-021 out_valid SHALL equal (count != 0); out_result/out_rd/out_overflow SHALL be 0 when count == 0, else head-entry contents.
REQ-022 An accepted result with in_rd == 0 SHALL be consumed (handshake completes) but SHALL NOT be stored; count unchanged by it.
REQ-023 Entries SHALL leave in arrival order; write and read pointers SHALL wrap modulo DEPTH.
REQ-024 Latency: a result pushed into an empty buffer in cycle N SHALL appear with out_valid = 1 in cycle N+1 (no bypass).
REQ-025 Simultaneous stored push and pop SHALL leave count unchanged, including when count == DEPTH is not possible since in_ready = 0 at full.
REQ-026 Pop with count == 0 SHALL be impossible (out_valid = 0); out_ready while empty SHALL have no effect.
REQ-027 flush SHALL, at the next edge, set count, read and write pointers to 0; any push or pop in the flush cycle SHALL be discarded.
REQ-028 ovf_sticky SHALL set on any accepted push with in_overflow = 1 (including in_rd == 0 and flush cycles); ovf_clear SHALL clear it; set SHALL win over simultaneous clear.
REQ-029 flush SHALL NOT modify ovf_sticky.
REQ-030 count SHALL never exceed DEPTH; stored entry data SHALL be unchanged while resident.

Reset
REQ-031 RST high SHALL immediately force count = 0, pointers = 0, ovf_sticky = 0, out_valid = 0, out_result/out_rd/out_overflow = 0, in_ready = 1.
REQ-032 RST asserted mid-transfer SHALL discard all queued entries; no pop SHALL be reported after RST deasserts until a new push.
REQ-033 Storage array contents need not be reset.

Verification
REQ-034 Single result: push {0x0000_0005, rd=3, ovf=0} into empty -> cycle N+1 out_valid=1, out_result=5, out_rd=3, count=1; pop -> count=0, outputs 0.
REQ-035 Fill/drain with DEPTH=4, out_ready=0: push 1,2,3,4 (rd=1..4) -> count=4, in_ready=0, 5th in_valid not accepted; then out_ready=1 -> 1,2,3,4 out in order, wrap verified by second pass of 5..8.
REQ-036 x0 discard: push {0xDEAD_BEEF, rd=0, ovf=1} -> in_ready handshake completes, count stays 0, out_valid=0, ovf_sticky=1.
REQ-037 Concurrent push/pop at count=2 for 10 cycles -> count stays 2, output order preserved; ovf_clear and overflowing push in same cycle -> ovf_sticky=1.
REQ-038 flush at count=3 with simultaneous push and pop -> next cycle count=0, out_valid=0, ovf_sticky unchanged; async RST pulse between edges at count=2 -> count=0 and out_valid=0 without a clock edge.
